spi_segment_master: RTL and testbench
=====================================

# spi_segment_master

SPI controller (mode 0, 8-bit frames) that drives the segment controller's SPI peripheral from the other end of the link. It generates `sck`, `cs_n` and `mosi`, and captures `miso`. Each transfer is started by a byte handed over on a valid/ready handshake, and the received byte is returned on a one-cycle strobe. It is used as the on-chip bench/host driver and in a standalone host-side build that talks to a segment-controller tile.

## Interface
Parameters:
- `CLK_DIV`, default 4: `sck` half-period in `clk` cycles. Legal range 1..255; the counter width is `$clog2(CLK_DIV+1)`.

Ports:
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `tx_data`  input  8  byte to send; sampled only at acceptance.
- `tx_valid`  input  1  request to start a frame.
- `tx_ready`  output  1  high only in IDLE; acceptance = `tx_valid & tx_ready` at a rising edge.
- `rx_data`  output  8  last received byte; holds until the next frame completes.
- `rx_valid`  output  1  one-cycle pulse when `rx_data` updates.
- `busy`  output  1  high from the cycle after acceptance until frame end.
- `sck`  output  1  SPI clock; idles low.
- `mosi`  output  1  SPI data out.
- `miso`  input  1  SPI data in.
- `cs_n`  output  1  chip select, active low.

## Operation
- Reset values: `sck`=0, `cs_n`=1, `mosi`=0, `tx_ready`=1, `busy`=0, `rx_valid`=0, `rx_data`=8'h00, state=IDLE.
- States: IDLE, SETUP, HIGH, LOW. Bit counter runs 0..7; divider counter runs 0..CLK_DIV-1.
- IDLE: `cs_n`=1, `sck`=0, `tx_ready`=1. On acceptance, `tx_data` is latched into the shift register and the state goes to SETUP.
- SETUP (CLK_DIV cycles): `cs_n`=0, `sck`=0, `mosi`=first bit, then go to HIGH.
- HIGH (CLK_DIV cycles): `sck`=1. `miso` is registered into the receive shift register on the same edge that drives `sck` 0→1. Then go to LOW.
- LOW (CLK_DIV cycles): `sck`=0.
  - For bits 0..6, `mosi` advances to the next bit on the edge that drives `sck` 1→0; then go to HIGH and increment the bit counter.
  - After bit 7, LOW acts as the CS hold time and `mosi` keeps the last bit. On its final edge: `cs_n`→1, `rx_data` ← assembled byte, `rx_valid`=1 for one cycle, state→IDLE.
- `tx_valid` is ignored while not in IDLE. Changes to `tx_data` after acceptance have no effect.
- Bit order: MSB first by default (see Configuration). The receive shift uses the same order as transmit.
- `rst` asserted at any point aborts the frame within one cycle: all outputs return to reset values, no `rx_valid` is generated and the partial byte is discarded.

## Timing
- Acceptance edge → `cs_n` low on the next cycle.
- `cs_n` low duration = 17·CLK_DIV cycles (SETUP + 8×HIGH + 8×LOW).
- 8 `sck` rising edges per frame, each high for exactly CLK_DIV cycles. `sck` period = 2·CLK_DIV cycles.
- `rx_valid`, `cs_n` rise and `tx_ready` rise all occur on the same cycle. A new frame can be accepted on that cycle's edge, so `cs_n` is high for at least 1 cycle between back-to-back frames.
- Throughput is one byte per 17·CLK_DIV+1 cycles.
- With CLK_DIV=1, `sck` toggles every cycle with no bubbles.

## Configuration
- `SPI_MASTER_LSB_FIRST_EN`:
  - Defined: transmit and receive LSB first. `mosi` carries `tx_data[0]` in SETUP, and the first sampled `miso` bit lands in `rx_data[0]`.
  - Undefined (default): MSB first, so `tx_data[7]` goes out first and the first sampled bit lands in `rx_data[7]`.
  - Timing is identical in both builds.

## Test plan
- CLK_DIV=2, `mosi` looped to `miso`, send 8'hA5 → `cs_n` low exactly 34 cycles, 8 `sck` rising edges, `rx_valid` single pulse with `rx_data`=8'hA5.
- `miso` tied 1, send 8'h00 → `mosi` observed 0 on all 8 rising edges, `rx_data`=8'hFF. Then `miso` tied 0, send 8'hFF → `rx_data`=8'h00.
- `tx_valid` held high with bytes 8'h12, 8'h34 → two frames, `cs_n` high exactly 1 cycle between them, `rx_data` 8'h12 then 8'h34 (loopback). `tx_valid` pulses during a frame are ignored.
- `rst` asserted for 1 cycle after the 4th `sck` rising edge → next cycle `sck`=0, `cs_n`=1, `tx_ready`=1, no `rx_valid`. A following 8'h3C frame completes correctly.
- CLK_DIV=1, loopback 8'h81 → `cs_n` low 17 cycles, `rx_data`=8'h81.
- Build with `SPI_MASTER_LSB_FIRST_EN`, send 8'h01 with a slave model returning 8'h80 LSB first → `mosi`=1 on the first rising edge, then 0 for the rest, and `rx_data`=8'h80.

Source files
------------

// File: rtl/spi_segment_master.sv
// SPI mode-0 master, 8-bit frames, valid/ready byte handoff and one-cycle rx strobe.
// Build option: define SPI_MASTER_LSB_FIRST_EN for LSB-first transmit and receive.
module spi_segment_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);

    // state | meaning
    // IDLE  | cs_n high, waiting for a byte
    // SETUP | cs_n low, first bit on mosi before the first sck rise
    // HIGH  | sck high; miso captured on the edge entering this state
    // LOW   | sck low; next bit presented, or cs hold after bit 7
    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_shift, tx_shift_nxt;
    logic [7:0]    rx_shift, rx_shift_nxt;
    logic          div_done, last_bit, accept;

    assign div_done = (div_cnt == DIV_LAST);
    assign last_bit = (bit_cnt == 3'd7);
    assign accept   = tx_valid && (state == IDLE);
    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign mosi         = tx_shift[0];
    assign tx_shift_nxt = {1'b0, tx_shift[7:1]};
    assign rx_shift_nxt = {miso, rx_shift[7:1]};
`else
    assign mosi         = tx_shift[7];
    assign tx_shift_nxt = {tx_shift[6:0], 1'b0};
    assign rx_shift_nxt = {rx_shift[6:0], miso};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept)   state_nxt = SETUP;
            SETUP: if (div_done) state_nxt = HIGH;
            HIGH:  if (div_done) state_nxt = LOW;
            LOW:   if (div_done) state_nxt = last_bit ? IDLE : HIGH;
            default:             state_nxt = IDLE;
        endcase
    end

    // sck and cs_n come straight from flops so the pins never glitch on state decode
    always_ff @(posedge clk) begin
        if (rst) begin
            sck      <= 1'b0;
            cs_n     <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= 3'd0;
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            sck      <= (state_nxt == HIGH);
            cs_n     <= (state_nxt == IDLE);
            rx_valid <= 1'b0;
            if (state == IDLE || div_done) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_shift <= tx_data;
                        bit_cnt  <= 3'd0;
                    end
                end
                SETUP: begin
                    if (div_done) rx_shift <= rx_shift_nxt;
                end
                HIGH: begin
                    if (div_done && !last_bit) tx_shift <= tx_shift_nxt;
                end
                LOW: begin
                    if (div_done) begin
                        if (last_bit) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                        end else begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            rx_shift <= rx_shift_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_segment_master.sv
// Self-checking bench for spi_segment_master: CLK_DIV=2 main instance, CLK_DIV=1 loopback instance.
module tb_spi_segment_master;

`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, rx_valid, busy, sck, mosi, cs_n;
    logic [7:0] rx_data;
    logic       miso;

    logic [7:0] tx1_data = 8'h00;
    logic       tx1_valid = 1'b0;
    logic       tx1_ready, rx1_valid, busy1, sck1, mosi1, cs1_n, miso1;
    logic [7:0] rx1_data;

    int n_checks = 0;
    int n_fail = 0;

    // miso source: 0 loopback, 1 constant, 2 slave shifting out slave_byte
    int         miso_mode = 0;
    logic       miso_const = 1'b0;
    logic [7:0] slave_byte = 8'h00;
    int         slave_idx = 0;
    logic       slave_bit;

    spi_segment_master #(.CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .sck(sck), .mosi(mosi),
        .miso(miso), .cs_n(cs_n)
    );

    spi_segment_master #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .tx_data(tx1_data), .tx_valid(tx1_valid), .tx_ready(tx1_ready),
        .rx_data(rx1_data), .rx_valid(rx1_valid), .busy(busy1), .sck(sck1), .mosi(mosi1),
        .miso(miso1), .cs_n(cs1_n)
    );

    assign miso1 = mosi1;

    always #5 clk = ~clk;

    // mode-0 slave: first bit valid at cs_n fall, next bit after each sck fall
    always @(negedge sck or posedge cs_n) begin
        if (cs_n) slave_idx <= 0;
        else      slave_idx <= slave_idx + 1;
    end

    always_comb begin
        slave_bit = 1'b0;
        if (slave_idx < 8) slave_bit = LSB_FIRST ? slave_byte[slave_idx] : slave_byte[7 - slave_idx];
    end

    always_comb begin
        miso = 1'b0;
        case (miso_mode)
            0: miso = mosi;
            1: miso = miso_const;
            2: miso = slave_bit;
            default: miso = 1'b0;
        endcase
    end

    // mosi values seen at successive sck rises, first bit in position 7
    function automatic logic [7:0] exp_mosi_seq(input logic [7:0] tx);
        logic [7:0] seq;
        seq = 8'h00;
        for (int k = 0; k < 8; k++) seq[7 - k] = LSB_FIRST ? tx[k] : tx[7 - k];
        return seq;
    endfunction

    task automatic do_frame(input logic [7:0] tx, input bit pulse,
                            output int low_cyc, output int rises, output logic [7:0] mosi_seq,
                            output int rxv, output logic [7:0] rxd, output bit cs_at_end, output bit ok);
        logic psck;
        low_cyc = 0; rises = 0; mosi_seq = 8'h00; rxv = 0; rxd = 8'h00; cs_at_end = 1'b0; ok = 1'b0;
        psck = 1'b0;
        @(negedge clk);
        tx_data = tx;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
        for (int i = 0; i < 200; i++) begin
            if (pulse && i == 5) tx_valid = 1'b1;
            if (pulse && i == 7) tx_valid = 1'b0;
            if (!cs_n) low_cyc++;
            if (sck && !psck) begin
                if (rises < 8) mosi_seq[7 - rises] = mosi;
                rises++;
            end
            psck = sck;
            if (rx_valid) begin
                rxv++;
                rxd = rx_data;
                cs_at_end = cs_n;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        @(negedge clk);
        if (rx_valid) rxv++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck got=%b exp=0", sck); end
        n_checks++; if (cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
        n_checks++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        n_checks++; if ({sck1, cs1_n, tx1_ready} !== 3'b011) begin n_fail++; $display("FAIL reset_dut1 got=%b exp=011", {sck1, cs1_n, tx1_ready}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_loopback_a5();
        int lc, rs, rv; logic [7:0] ms, rd; bit ce, ok;
        miso_mode = 0;
        do_frame(8'hA5, 1'b0, lc, rs, ms, rv, rd, ce, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL a5_timeout got=%b exp=1", ok); end
        n_checks++; if (lc != 34) begin n_fail++; $display("FAIL a5_cs_low got=%0d exp=34", lc); end
        n_checks++; if (rs != 8) begin n_fail++; $display("FAIL a5_sck_rises got=%0d exp=8", rs); end
        n_checks++; if (ms !== exp_mosi_seq(8'hA5)) begin n_fail++; $display("FAIL a5_mosi got=%h exp=%h", ms, exp_mosi_seq(8'hA5)); end
        n_checks++; if (rv != 1) begin n_fail++; $display("FAIL a5_rx_valid_pulses got=%0d exp=1", rv); end
        n_checks++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL a5_rx_data got=%h exp=a5", rd); end
        n_checks++; if (ce !== 1'b1) begin n_fail++; $display("FAIL a5_cs_with_rx_valid got=%b exp=1", ce); end
    endtask

    task automatic test_miso_const();
        int lc, rs, rv; logic [7:0] ms, rd; bit ce, ok;
        miso_mode = 1;
        miso_const = 1'b1;
        do_frame(8'h00, 1'b0, lc, rs, ms, rv, rd, ce, ok);
        n_checks++; if (ms !== 8'h00) begin n_fail++; $display("FAIL const1_mosi got=%h exp=00", ms); end
        n_checks++; if (rd !== 8'hFF || rv != 1) begin n_fail++; $display("FAIL const1_rx got=%h/%0d exp=ff/1", rd, rv); end
        miso_const = 1'b0;
        do_frame(8'hFF, 1'b0, lc, rs, ms, rv, rd, ce, ok);
        n_checks++; if (ms !== 8'hFF) begin n_fail++; $display("FAIL const0_mosi got=%h exp=ff", ms); end
        n_checks++; if (rd !== 8'h00 || rv != 1) begin n_fail++; $display("FAIL const0_rx got=%h/%0d exp=00/1", rd, rv); end
        miso_mode = 0;
    endtask

    task automatic test_random_frames();
        int lc, rs, rv; logic [7:0] ms, rd, tx; bit ce, ok, pulse;
        miso_mode = 2;
        for (int n = 0; n < 8; n++) begin
            tx = 8'($urandom);
            slave_byte = 8'($urandom);
            pulse = 1'($urandom);
            do_frame(tx, pulse, lc, rs, ms, rv, rd, ce, ok);
            n_checks++; if (lc != 34 || rs != 8 || rv != 1) begin n_fail++; $display("FAIL rand%0d_timing got=%0d/%0d/%0d exp=34/8/1", n, lc, rs, rv); end
            n_checks++; if (ms !== exp_mosi_seq(tx)) begin n_fail++; $display("FAIL rand%0d_mosi got=%h exp=%h", n, ms, exp_mosi_seq(tx)); end
            n_checks++; if (rd !== slave_byte) begin n_fail++; $display("FAIL rand%0d_rx got=%h exp=%h", n, rd, slave_byte); end
            n_checks++; if (cs_n !== 1'b1 || tx_ready !== 1'b1) begin n_fail++; $display("FAIL rand%0d_idle_after got=%b%b exp=11", n, cs_n, tx_ready); end
        end
        miso_mode = 0;
    endtask

    task automatic test_slave_order();
        int lc, rs, rv; logic [7:0] ms, rd; bit ce, ok;
        miso_mode = 2;
        slave_byte = 8'h80;
        do_frame(8'h01, 1'b0, lc, rs, ms, rv, rd, ce, ok);
        n_checks++; if (ms !== exp_mosi_seq(8'h01)) begin n_fail++; $display("FAIL order_mosi got=%h exp=%h", ms, exp_mosi_seq(8'h01)); end
        n_checks++; if (rd !== 8'h80) begin n_fail++; $display("FAIL order_rx got=%h exp=80", rd); end
        miso_mode = 0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] got[$];
        int gap, done;
        miso_mode = 0;
        gap = 0; done = 0;
        @(negedge clk);
        tx_data = 8'h12;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h34;
        for (int i = 0; i < 300 && done < 2; i++) begin
            if (rx_valid) begin
                got.push_back(rx_data);
                done++;
            end
            if (done == 1 && cs_n) gap++;
            if (done == 1 && !cs_n) tx_valid = 1'b0;
            if (done < 2) @(negedge clk);
        end
        tx_valid = 1'b0;
        n_checks++; if (done != 2) begin n_fail++; $display("FAIL b2b_frames got=%0d exp=2", done); end
        n_checks++; if (gap != 1) begin n_fail++; $display("FAIL b2b_cs_gap got=%0d exp=1", gap); end
        n_checks++; if (got.size() != 2 || got[0] !== 8'h12 || got[1] !== 8'h34) begin
            n_fail++; $display("FAIL b2b_rx got=%p exp='{12,34}", got);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lc, rs, rv, rises, bad; logic [7:0] ms, rd; bit ce, ok; logic psck;
        miso_mode = 0;
        rises = 0; psck = 1'b0; bad = 0;
        @(negedge clk);
        tx_data = 8'($urandom);
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < 100 && rises < 4; i++) begin
            if (sck && !psck) rises++;
            psck = sck;
            if (rises < 4) @(negedge clk);
        end
        n_checks++; if (rises != 4) begin n_fail++; $display("FAIL rstmid_reach got=%0d exp=4", rises); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if ({sck, cs_n, tx_ready, rx_valid, mosi, busy} !== 6'b011000) begin
            n_fail++; $display("FAIL rstmid_outputs got=%b exp=011000", {sck, cs_n, tx_ready, rx_valid, mosi, busy});
        end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx_data got=%h exp=00", rx_data); end
        for (int i = 0; i < 40; i++) begin
            if (rx_valid || !cs_n) bad++;
            @(negedge clk);
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_quiet got=%0d exp=0", bad); end
        do_frame(8'h3C, 1'b0, lc, rs, ms, rv, rd, ce, ok);
        n_checks++; if (rd !== 8'h3C || lc != 34 || rs != 8) begin n_fail++; $display("FAIL rstmid_next got=%h/%0d/%0d exp=3c/34/8", rd, lc, rs); end
    endtask

    task automatic test_clkdiv1();
        int low, rises; logic [7:0] rd; bit seen; logic psck;
        low = 0; rises = 0; rd = 8'h00; seen = 1'b0; psck = 1'b0;
        @(negedge clk);
        tx1_data = 8'h81;
        tx1_valid = 1'b1;
        @(negedge clk);
        tx1_valid = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (!cs1_n) low++;
            if (sck1 && !psck) rises++;
            psck = sck1;
            if (rx1_valid) begin
                seen = 1'b1;
                rd = rx1_data;
            end
            if (!seen) @(negedge clk);
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL div1_timeout got=%b exp=1", seen); end
        n_checks++; if (low != 17) begin n_fail++; $display("FAIL div1_cs_low got=%0d exp=17", low); end
        n_checks++; if (rises != 8) begin n_fail++; $display("FAIL div1_sck_rises got=%0d exp=8", rises); end
        n_checks++; if (rd !== 8'h81) begin n_fail++; $display("FAIL div1_rx got=%h exp=81", rd); end
    endtask

    initial begin
        test_reset();
        test_loopback_a5();
        test_miso_const();
        test_back_to_back();
        test_reset_mid();
        test_clkdiv1();
        test_slave_order();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
